// File: rtl/ocx_dlx_xlx_tx_if.sv
// TX-side bring-up sequencer between the DLx and the PHY. Waits for the PHY
// TX path to be stably ready, holds until the far end is ready (or we are
// told to send first), then lets the DLx transmit. A retrain request pulses
// the PHY TX datapath reset and watches for the PHY to acknowledge it.
module ocx_dlx_xlx_tx_if #(
  parameter int STABLE_CYCLES = 8,   // 2..256
  parameter int PULSE_CYCLES  = 8,   // 1..256
  parameter int DONE_TIMEOUT  = 255  // 1..255
) (
  input  logic       opt_gckn,
  input  logic       ocde,
  input  logic       gtwiz_reset_tx_done_in,
  input  logic       gtwiz_buffbypass_tx_done_in,
  input  logic       gtwiz_userclk_tx_active_in,
  input  logic       send_first,
  input  logic [7:0] io_pb_o0_rx_init_done,
  input  logic       dlx_tx_retrain_req,
  output logic       gtwiz_reset_tx_datapath_out,
  output logic       dlx_tx_start,
  output logic       tx_timeout_err,
  output logic [3:0] tx_loss_count,
  output logic [2:0] tx_state
);

  typedef enum logic [2:0] {
    TX_WAIT       = 3'b000,
    TX_HOLD       = 3'b001,
    TX_RUN        = 3'b010,
    TX_PULSE      = 3'b011,
    TX_PULSE_DONE = 3'b100
  } state_e;

  // Terminal counts; all three counters are 8 bits wide and every legal
  // parameter value minus one fits.
  localparam logic [7:0] STB_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] PLS_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] TMO_LAST = 8'(DONE_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] stable_q, stable_d;
  logic [7:0] pulse_q, pulse_d;
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;
  logic [3:0] loss_q, loss_d;

  // PHY status is already in this clock domain, so no synchronizers.
  logic tx_ready, rx_all_done;
  assign tx_ready    = gtwiz_reset_tx_done_in & gtwiz_buffbypass_tx_done_in &
                       gtwiz_userclk_tx_active_in;
  assign rx_all_done = &io_pb_o0_rx_init_done;

  // Next state and counters. Counters default to zero so each one is
  // already cleared on entry to the state that uses it.
  always_comb begin
    state_d  = state_q;
    stable_d = '0;
    pulse_d  = '0;
    tmo_d    = '0;
    err_d    = err_q;
    loss_d   = loss_q;
    case (state_q)
      TX_WAIT: begin
        if (tx_ready) begin
          if (stable_q == STB_LAST) state_d = TX_HOLD;
          else                      stable_d = stable_q + 8'd1;
        end
      end
      TX_HOLD: begin
        if (!tx_ready)                      state_d = TX_WAIT;
        else if (send_first || rx_all_done) state_d = TX_RUN;
      end
      TX_RUN: begin
        // Losing ready wins; a coincident retrain request is simply dropped.
        if (!tx_ready) begin
          state_d = TX_WAIT;
          if (loss_q != 4'hF) loss_d = loss_q + 4'd1;
        end else if (dlx_tx_retrain_req) begin
          state_d = TX_PULSE;
        end
      end
      TX_PULSE: begin
        if (pulse_q == PLS_LAST) state_d = TX_PULSE_DONE;
        else                     pulse_d = pulse_q + 8'd1;
      end
      TX_PULSE_DONE: begin
        // PHY dropping both done lines is the acknowledge; it beats timeout.
        if (!gtwiz_reset_tx_done_in && !gtwiz_buffbypass_tx_done_in) begin
          state_d = TX_WAIT;
        end else if (tmo_q == TMO_LAST) begin
          state_d = TX_WAIT;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = TX_WAIT;
    endcase
  end

  // State and counter registers; sticky error and loss count clear only on reset.
  always_ff @(posedge opt_gckn or negedge ocde) begin
    if (!ocde) begin
      state_q  <= TX_WAIT;
      stable_q <= '0;
      pulse_q  <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      loss_q   <= '0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      loss_q   <= loss_d;
    end
  end

  // Outputs decode straight from the state register, so reset drops them at once.
  assign gtwiz_reset_tx_datapath_out = (state_q == TX_PULSE);
  assign dlx_tx_start                = (state_q == TX_RUN);
  assign tx_timeout_err              = err_q;
  assign tx_loss_count               = loss_q;
  assign tx_state                    = state_q;

endmodule

// File: tb/tb_ocx_dlx_xlx_tx_if.sv
// Bench for ocx_dlx_xlx_tx_if: directed bring-up/retrain scenarios followed by
// random traffic, with a cycle-level reference model feeding a scoreboard.
module tb_ocx_dlx_xlx_tx_if;
  localparam int STB = 8, PLS = 8, DTO = 255;

  logic       clk = 1'b0, ocde = 1'b0;
  logic       tx_done = 1'b0, bb_done = 1'b0, uclk = 1'b0;
  logic       send_first = 1'b0, retrain = 1'b0;
  logic [7:0] rx_init = 8'h00;
  logic       pulse_o, start_o, err_o;
  logic [3:0] loss_o;
  logic [2:0] st_o;

  always #5 clk = ~clk;

  ocx_dlx_xlx_tx_if dut (
    .opt_gckn                    (clk),
    .ocde                        (ocde),
    .gtwiz_reset_tx_done_in      (tx_done),
    .gtwiz_buffbypass_tx_done_in (bb_done),
    .gtwiz_userclk_tx_active_in  (uclk),
    .send_first                  (send_first),
    .io_pb_o0_rx_init_done       (rx_init),
    .dlx_tx_retrain_req          (retrain),
    .gtwiz_reset_tx_datapath_out (pulse_o),
    .dlx_tx_start                (start_o),
    .tx_timeout_err              (err_o),
    .tx_loss_count               (loss_o),
    .tx_state                    (st_o)
  );

  typedef struct { logic [2:0] st; logic start, pls, err; logic [3:0] loss; } exp_t;
  typedef struct { string nm; int sel; int val; } dchk_t;
  exp_t  exp_q[$];
  dchk_t dq[$];
  int n_chk = 0, n_pass = 0, ncyc = 0;

  // Reference model: phase numbers are the published state encodings.
  // run_len = consecutive ready cycles seen while waiting, age = cycles spent
  // in the pulse / acknowledge phases.
  int ph, run_len, age, m_loss;
  bit m_err;

  function automatic void model_reset();
    ph = 0; run_len = 0; age = 0; m_err = 0; m_loss = 0;
  endfunction

  task automatic model_step();
    bit rdy;
    rdy = tx_done & bb_done & uclk;
    if (!ocde) begin model_reset(); return; end
    case (ph)
      0: begin
        run_len = rdy ? run_len + 1 : 0;
        if (run_len == STB) begin ph = 1; run_len = 0; end
      end
      1: if (!rdy) ph = 0; else if (send_first || rx_init == 8'hFF) ph = 2;
      2: begin
        if (!rdy) begin ph = 0; if (m_loss < 15) m_loss++; end
        else if (retrain) begin ph = 3; age = 0; end
      end
      3: begin age++; if (age == PLS) begin ph = 4; age = 0; end end
      4: begin
        age++;
        if (!tx_done && !bb_done) ph = 0;
        else if (age == DTO) begin ph = 0; m_err = 1; end
      end
      default: ph = 0;
    endcase
  endtask

  // One clock: advance the model on the edge, optionally hit reset
  // asynchronously just after it, then queue what the DUT must show.
  task automatic cyc(input bit rst_mid = 1'b0);
    exp_t e;
    @(posedge clk);
    model_step();
    if (rst_mid) begin #1; ocde = 1'b0; model_reset(); end
    e.st = 3'(ph); e.start = (ph == 2); e.pls = (ph == 3);
    e.err = m_err; e.loss = 4'(m_loss);
    exp_q.push_back(e);
    #1;
    ncyc++;
  endtask

  // Directed expectation on one output (0 state,1 start,2 pulse,3 err,4 loss).
  task automatic dexp(input string nm, input int sel, input int val);
    dchk_t d;
    d.nm = nm; d.sel = sel; d.val = val;
    dq.push_back(d);
  endtask

  function automatic int act(input int sel);
    case (sel)
      0: return int'(st_o);
      1: return int'(start_o);
      2: return int'(pulse_o);
      3: return int'(err_o);
      default: return int'(loss_o);
    endcase
  endfunction

  function automatic void chk(input string nm, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, ncyc, got, want);
  endfunction

  // Monitor: compare on the falling edge, away from the sampling edge.
  initial begin
    exp_t  e;
    dchk_t d;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", int'(st_o), int'(e.st));
        chk("tx_start", int'(start_o), int'(e.start));
        chk("datapath_rst", int'(pulse_o), int'(e.pls));
        chk("timeout_err", int'(err_o), int'(e.err));
        chk("loss_count", int'(loss_o), int'(e.loss));
      end
      while (dq.size() > 0) begin
        d = dq.pop_front();
        chk(d.nm, act(d.sel), d.val);
      end
    end
  end

  task automatic to_run();
    tx_done = 1; bb_done = 1; uclk = 1; send_first = 1; retrain = 0; ocde = 1;
    for (int i = 0; i < 24 && ph != 2; i++) cyc();
    dexp("reach_run", 1, 1);
  endtask

  initial begin
    model_reset();
    // Reset held: everything at rest even with live inputs.
    tx_done = 1; bb_done = 1; uclk = 1; retrain = 1; send_first = 1;
    for (int i = 0; i < 3; i++) cyc();
    dexp("rst_state", 0, 0);
    retrain = 0;

    // Send-first bring-up: HOLD after 8 edges, start on edge 9.
    ocde = 1;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      if (i == 7) dexp("wait_at_7", 0, 0);
      if (i == 8) dexp("hold_at_8", 0, 1);
      if (i == 9) dexp("start_at_9", 1, 1);
    end

    // Ready glitch at stable count 5 restarts the count.
    cyc(1'b1);
    ocde = 1; send_first = 0; rx_init = 8'hFE;
    for (int i = 0; i < 5; i++) cyc();
    uclk = 0; cyc(); uclk = 1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i == 7) dexp("restart_wait", 0, 0);
      if (i == 8) dexp("restart_hold", 0, 1);
    end

    // Wait for receiver init: one lane short for 20 cycles.
    for (int i = 0; i < 20; i++) begin cyc(); dexp("rx_fe_nostart", 1, 0); end
    rx_init = 8'hFF;
    cyc(); dexp("rx_ff_start", 1, 1);

    // Retrain, PHY acknowledges at acknowledge-phase cycle 3.
    retrain = 1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (k == 0) retrain = 0;
      dexp("pulse_len", 2, (k < PLS) ? 1 : 0);
    end
    cyc(); dexp("ack_wait", 0, 4);
    tx_done = 0; bb_done = 0;
    cyc(); dexp("ack_to_wait", 0, 0); dexp("ack_no_err", 3, 0);

    // Retrain, PHY never acknowledges: timeout sets sticky error.
    to_run();
    retrain = 1;
    for (int k = 1; k <= PLS + 1 + DTO; k++) begin
      cyc();
      if (k == 1) retrain = 0;
      if (k == PLS + DTO)     dexp("tmo_still_done", 0, 4);
      if (k == PLS + DTO + 1) begin dexp("tmo_wait", 0, 0); dexp("tmo_err", 3, 1); end
    end
    for (int i = 0; i < 4; i++) cyc();
    dexp("err_sticky", 3, 1);

    // Ready loss coincident with retrain: loss counted, no pulse.
    to_run();
    uclk = 0; retrain = 1;
    cyc(); dexp("drop_wins_state", 0, 0); dexp("drop_wins_loss", 4, 1);
    retrain = 0;
    cyc(); dexp("retrain_not_queued", 2, 0);
    // Sixteen more losses saturate the count at 15.
    for (int n = 0; n < 16; n++) begin
      to_run();
      repeat ($urandom_range(0, 3)) cyc();
      case ($urandom_range(0, 2))
        0: tx_done = 0;
        1: bb_done = 0;
        default: uclk = 0;
      endcase
      cyc();
    end
    dexp("loss_saturate", 4, 15);

    // Reset in the middle of the pulse drops it without a clock edge.
    to_run();
    retrain = 1; cyc(); retrain = 0;
    cyc(); cyc();
    cyc(1'b1);
    dexp("rst_mid_pulse", 2, 0); dexp("rst_mid_state", 0, 0);
    dexp("rst_clr_err", 3, 0); dexp("rst_clr_loss", 4, 0);
    cyc();
    ocde = 1;

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        tx_done = ($urandom_range(0, 9) != 0);
        bb_done = ($urandom_range(0, 9) != 0);
        uclk    = ($urandom_range(0, 9) != 0);
      end
      send_first = ($urandom_range(0, 3) == 0);
      rx_init    = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
      retrain    = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 299) == 0) cyc(1'b1);
      else begin ocde = 1; cyc(); end
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
